// File: rtl/pc_predict_unit_pkg.sv
// Shared encodings and helpers for the fetch-stage PC predictor.
// PC source codes come from the execute stage; BTB counters are 2-bit saturating.
package pc_predict_unit_pkg;

  typedef enum logic [2:0] {
    PC_NEXT            = 3'd0,
    PC_ALWAYS_BRANCH   = 3'd1,
    PC_JALR            = 3'd2,
    PC_COND_BRANCH     = 3'd3,
    PC_INV_COND_BRANCH = 3'd4
  } pc_src_e;

  localparam logic [1:0] BTB_CTR_INIT  = 2'b01;
  localparam logic [1:0] BTB_CTR_ALLOC = 2'b10;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_predict_unit_btb_table.sv
// Direct-mapped BTB storage: one async read port for fetch lookup and one
// sync read-modify-write port that trains the entry selected by execute.
module pc_predict_unit_btb_table
  import pc_predict_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = WIDTH - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic             rd_pred_taken,
  output logic [WIDTH-1:0] rd_tgt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [WIDTH-1:0] wr_tgt
);

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][WIDTH-1:0] tgt_q, tgt_d;
  logic                          wr_hit_s;

  assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_pred_taken = ctr_q[rd_idx][1];
  assign rd_tgt        = tgt_q[rd_idx];
  assign wr_hit_s      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Training: hits move the counter, taken misses replace the victim entry.
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (wr_en && wr_hit_s) begin
      ctr_d[wr_idx] = ctr_update(ctr_q[wr_idx], wr_taken);
      if (wr_taken) begin
        tgt_d[wr_idx] = wr_tgt;
      end else begin
        tgt_d[wr_idx] = tgt_q[wr_idx];
      end
    end else if (wr_en && wr_taken) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      tgt_d[wr_idx]   = wr_tgt;
      ctr_d[wr_idx]   = BTB_CTR_ALLOC;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits and counters clear asynchronously; that alone invalidates every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{BTB_CTR_INIT}};
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target payload need no reset because valid gates them.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC generator: BTB-based next-PC prediction, execute-stage resolution,
// redirect/flush on mispredict, saturating mispredict counter.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pred_next,
  input  logic             ex_valid,
  input  logic [2:0]       ex_PCsrc,
  input  logic             ex_EQ,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_pc_plus4,
  input  logic [WIDTH-1:0] ex_branch_tgt,
  input  logic [WIDTH-1:0] ex_jalr_tgt,
  input  logic [WIDTH-1:0] ex_pred_next,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic             bad_pcsrc
);

  localparam int               IDX_W   = $clog2(BTB_ENTRIES);
  localparam int               TAG_W   = WIDTH - IDX_W - 2;
  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic [WIDTH-1:0] actual_s, pred_next_s, btb_tgt_s;
  logic             pcsrc_ok_s, taken_s, mispredict_s, btb_hit_s, btb_taken_s, btb_wr_en_s;
  logic             unused_ex_pc_lsb_s;

  assign unused_ex_pc_lsb_s = ^ex_pc[1:0];

  pc_predict_unit_btb_table #(
    .WIDTH  (WIDTH),
    .ENTRIES(BTB_ENTRIES)
  ) u_btb_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx       (pc_q[IDX_W+1:2]),
    .rd_tag       (pc_q[WIDTH-1:IDX_W+2]),
    .rd_hit       (btb_hit_s),
    .rd_pred_taken(btb_taken_s),
    .rd_tgt       (btb_tgt_s),
    .wr_en        (btb_wr_en_s),
    .wr_idx       (ex_pc[IDX_W+1:2]),
    .wr_tag       (ex_pc[WIDTH-1:IDX_W+2]),
    .wr_taken     (taken_s),
    .wr_tgt       (actual_s)
  );

  assign pred_next_s = (btb_hit_s && btb_taken_s) ? btb_tgt_s : pc_q + PC_STEP;

  // Resolve the real successor of the execute-stage instruction.
  always_comb begin
    actual_s   = ex_pc_plus4;
    pcsrc_ok_s = 1'b1;
    case (ex_PCsrc)
      PC_NEXT:            actual_s = ex_pc_plus4;
      PC_ALWAYS_BRANCH:   actual_s = ex_branch_tgt;
      PC_JALR:            actual_s = ex_jalr_tgt;
      PC_COND_BRANCH:     actual_s = ex_EQ ? ex_branch_tgt : ex_pc_plus4;
      PC_INV_COND_BRANCH: actual_s = ex_EQ ? ex_pc_plus4 : ex_branch_tgt;
      default: begin
        actual_s   = ex_pc_plus4;
        pcsrc_ok_s = 1'b0;
      end
    endcase
  end

  assign taken_s      = (actual_s != ex_pc_plus4);
  assign mispredict_s = ex_valid && pcsrc_ok_s && (actual_s != ex_pred_next);
  assign btb_wr_en_s  = ex_valid && pcsrc_ok_s && (ex_PCsrc != PC_NEXT);

  // A redirect wins over a hazard stall; otherwise follow the prediction.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    bad_d = bad_q | (ex_valid & ~pcsrc_ok_s);
    if (mispredict_s) begin
      pc_d = actual_s;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_next_s;
    end
    if (mispredict_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Architectural fetch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      bad_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      bad_q <= bad_d;
    end
  end

  assign pc             = pc_q;
  assign pred_next      = pred_next_s;
  assign flush          = mispredict_s;
  assign mispredict_cnt = cnt_q;
  assign bad_pcsrc      = bad_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: expected fetch PCs are queued when
// stimulus is driven and popped once the clock edge has updated the DUT.
module tb_pc_predict_unit;
  import pc_predict_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, ex_valid, ex_EQ;
  logic [2:0]  ex_PCsrc;
  logic [31:0] ex_pc, ex_pc_plus4, ex_branch_tgt, ex_jalr_tgt, ex_pred_next;
  logic [31:0] pc, pred_next;
  logic        flush, bad_pcsrc;
  logic [15:0] mispredict_cnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_pc;
  logic [15:0] exp_cnt = 16'd0;

  pc_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc), .pred_next(pred_next),
    .ex_valid(ex_valid), .ex_PCsrc(ex_PCsrc), .ex_EQ(ex_EQ), .ex_pc(ex_pc),
    .ex_pc_plus4(ex_pc_plus4), .ex_branch_tgt(ex_branch_tgt), .ex_jalr_tgt(ex_jalr_tgt),
    .ex_pred_next(ex_pred_next), .flush(flush), .mispredict_cnt(mispredict_cnt),
    .bad_pcsrc(bad_pcsrc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic idle();
    stall = 1'b0; ex_valid = 1'b0; ex_PCsrc = 3'd0; ex_EQ = 1'b0;
    ex_pc = 32'h0; ex_pc_plus4 = 32'h4; ex_branch_tgt = 32'h0; ex_jalr_tgt = 32'h0;
    ex_pred_next = 32'h4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [2:0] src, input logic eq, input logic [31:0] epc,
                          input logic [31:0] btgt, input logic [31:0] jtgt, input logic [31:0] pnext);
    ex_valid = 1'b1; ex_PCsrc = src; ex_EQ = eq; ex_pc = epc; ex_pc_plus4 = epc + 32'd4;
    ex_branch_tgt = btgt; ex_jalr_tgt = jtgt; ex_pred_next = pnext;
  endtask

  // Steers fetch to addr with a sequential-flow mispredict (no BTB training).
  task automatic redirect_to(input logic [31:0] addr);
    drive_ex(3'(PC_NEXT), 1'b0, addr - 32'd4, 32'h0, 32'h0, addr ^ 32'h8);
    step();
    exp_cnt = sat_inc(exp_cnt);
    idle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; idle();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    total++; if (pred_next !== 32'h4) begin bad++; $display("FAIL reset_pred: got %h want 00000004", pred_next); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush); end
    total++; if (mispredict_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0000", mispredict_cnt); end
    total++; if (bad_pcsrc !== 1'b0) begin bad++; $display("FAIL reset_bad: got %b want 0", bad_pcsrc); end
    rst_n = 1'b1;
    exp_pc_q.push_back(32'h4);
    step();
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL reset_release_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_cold_loop();
    drive_ex(3'(PC_COND_BRANCH), 1'b1, 32'h20, 32'h10, 32'h0, 32'h24);
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL cold_flush: got %b want 1", flush); end
    exp_pc_q.push_back(32'h10);
    step();
    exp_cnt = sat_inc(exp_cnt);
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL cold_pc: got %h want %h", pc, exp_pc); end
    idle();
    total++; if (mispredict_cnt !== exp_cnt) begin bad++; $display("FAIL cold_cnt: got %h want %h", mispredict_cnt, exp_cnt); end
    redirect_to(32'h20);
    total++; if (pred_next !== 32'h10) begin bad++; $display("FAIL cold_pred: got %h want 00000010", pred_next); end
  endtask

  task automatic test_training();
    for (int i = 0; i < 3; i++) begin
      drive_ex(3'(PC_COND_BRANCH), 1'b1, 32'h20, 32'h10, 32'h0, 32'h10);
      #1;
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL train_taken_flush%0d: got %b want 0", i, flush); end
      step();
      idle();
    end
    for (int k = 0; k < 2; k++) begin
      drive_ex(3'(PC_COND_BRANCH), 1'b0, 32'h20, 32'h10, 32'h0, 32'h10);
      #1;
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL train_nt_flush%0d: got %b want 1", k, flush); end
      exp_pc_q.push_back(32'h24);
      step();
      exp_cnt = sat_inc(exp_cnt);
      exp_pc = exp_pc_q.pop_front();
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL train_nt_pc%0d: got %h want %h", k, pc, exp_pc); end
      idle();
      redirect_to(32'h20);
      exp_pc = (k == 0) ? 32'h10 : 32'h24;
      total++; if (pred_next !== exp_pc) begin bad++; $display("FAIL train_pred%0d: got %h want %h", k, pred_next, exp_pc); end
    end
    total++; if (mispredict_cnt !== exp_cnt) begin bad++; $display("FAIL train_cnt: got %h want %h", mispredict_cnt, exp_cnt); end
  endtask

  task automatic test_jalr();
    drive_ex(3'(PC_JALR), 1'b0, 32'h40, 32'h0, 32'h80, 32'h44);
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL jalr_flush: got %b want 1", flush); end
    exp_pc_q.push_back(32'h80);
    step();
    exp_cnt = sat_inc(exp_cnt);
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL jalr_pc: got %h want %h", pc, exp_pc); end
    drive_ex(3'(PC_JALR), 1'b0, 32'h40, 32'h0, 32'h90, 32'h80);
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL jalr_retgt_flush: got %b want 1", flush); end
    exp_pc_q.push_back(32'h90);
    step();
    exp_cnt = sat_inc(exp_cnt);
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL jalr_retgt_pc: got %h want %h", pc, exp_pc); end
    idle();
    redirect_to(32'h40);
    total++; if (pred_next !== 32'h90) begin bad++; $display("FAIL jalr_pred: got %h want 00000090", pred_next); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    drive_ex(3'(PC_ALWAYS_BRANCH), 1'b0, 32'h104, 32'h200, 32'h0, 32'h108);
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL stall_redir_flush: got %b want 1", flush); end
    exp_pc_q.push_back(32'h200);
    step();
    exp_cnt = sat_inc(exp_cnt);
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL stall_redir_pc: got %h want %h", pc, exp_pc); end
    ex_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_pc_q.push_back(32'h200);
      step();
      exp_pc = exp_pc_q.pop_front();
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL stall_hold_pc%0d: got %h want %h", i, pc, exp_pc); end
    end
    total++; if (pred_next !== 32'h204) begin bad++; $display("FAIL stall_pred: got %h want 00000204", pred_next); end
    stall = 1'b0;
    exp_pc_q.push_back(32'h204);
    step();
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL stall_release_pc: got %h want %h", pc, exp_pc); end
    idle();
  endtask

  task automatic test_aliasing();
    drive_ex(3'(PC_ALWAYS_BRANCH), 1'b0, 32'h0, 32'h300, 32'h0, 32'h4);
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL alias_flush: got %b want 1", flush); end
    exp_pc_q.push_back(32'h300);
    step();
    exp_cnt = sat_inc(exp_cnt);
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL alias_pc: got %h want %h", pc, exp_pc); end
    idle();
    redirect_to(32'h40);
    total++; if (pred_next !== 32'h44) begin bad++; $display("FAIL alias_evicted_pred: got %h want 00000044", pred_next); end
    redirect_to(32'h0);
    total++; if (pred_next !== 32'h300) begin bad++; $display("FAIL alias_new_pred: got %h want 00000300", pred_next); end
  endtask

  task automatic test_bad_pcsrc();
    redirect_to(32'h500);
    stall = 1'b1;
    drive_ex(3'b111, 1'b1, 32'h600, 32'h700, 32'h700, 32'h123);
    #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL badsrc_flush: got %b want 0", flush); end
    exp_pc_q.push_back(32'h500);
    step();
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL badsrc_pc: got %h want %h", pc, exp_pc); end
    total++; if (bad_pcsrc !== 1'b1) begin bad++; $display("FAIL badsrc_set: got %b want 1", bad_pcsrc); end
    total++; if (mispredict_cnt !== exp_cnt) begin bad++; $display("FAIL badsrc_cnt: got %h want %h", mispredict_cnt, exp_cnt); end
    idle();
    step();
    total++; if (bad_pcsrc !== 1'b1) begin bad++; $display("FAIL badsrc_sticky: got %b want 1", bad_pcsrc); end
    redirect_to(32'h600);
    total++; if (pred_next !== 32'h604) begin bad++; $display("FAIL badsrc_no_train: got %h want 00000604", pred_next); end
  endtask

  task automatic test_saturation();
    drive_ex(3'(PC_NEXT), 1'b0, 32'h0, 32'h0, 32'h0, 32'h8);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      exp_cnt = sat_inc(exp_cnt);
    end
    #1;
    exp_pc_q.push_back(32'h4);
    idle();
    stall = 1'b1;
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL sat_pc: got %h want %h", pc, exp_pc); end
    total++; if (mispredict_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt: got %h want ffff", mispredict_cnt); end
    total++; if (mispredict_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt_model: got %h want %h", mispredict_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midrun();
    redirect_to(32'h0);
    step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL midrst_pc: got %h want 00000000", pc); end
    total++; if (pred_next !== 32'h4) begin bad++; $display("FAIL midrst_pred: got %h want 00000004", pred_next); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL midrst_flush: got %b want 0", flush); end
    total++; if (mispredict_cnt !== 16'h0) begin bad++; $display("FAIL midrst_cnt: got %h want 0000", mispredict_cnt); end
    total++; if (bad_pcsrc !== 1'b0) begin bad++; $display("FAIL midrst_bad: got %b want 0", bad_pcsrc); end
    step();
    rst_n = 1'b1;
    exp_pc_q.push_back(32'h4);
    step();
    exp_pc = exp_pc_q.pop_front();
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL midrst_release_pc: got %h want %h", pc, exp_pc); end
  endtask

  initial begin
    test_reset();
    test_cold_loop();
    test_training();
    test_jalr();
    test_stall_redirect();
    test_aliasing();
    test_bad_pcsrc();
    test_saturation();
    test_reset_midrun();
    total++;
    if (exp_pc_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_pc_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
